wb_arbiter: RTL and testbench

Writeback arbiter for QAR-Core: merges results from the single-cycle ALU path and the multi-cycle load/store unit (LSU) onto the register file's single write port. LSU results are buffered in a small FIFO. ALU results have priority, bounded by a starvation limit. The block also exports a pending-destination mask so decode can stall on registers whose writes are still in flight.

---
 rtl/qar_pkg.sv | 17 +
 rtl/wb_fifo.sv | 66 ++++++
 rtl/wb_arbiter.sv | 129 ++++++++++++
 tb/tb_wb_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/qar_pkg.sv
// rtl/qar_pkg.sv - shared QAR-Core widths and writeback request type
package qar_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of writeback requests with per-entry rd view
module wb_fifo
    import qar_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  wb_req_t                         push_req,
    input  logic                            pop,
    output wb_req_t                         head,
    output logic                            full,
    output logic                            empty,
    output logic [DEPTH-1:0]                ent_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [DEPTH-1:0] vld;
    wb_req_t          mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr                <= wr_ptr + (AW+1)'(1);
                vld[wr_ptr[AW-1:0]]   <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr                <= rd_ptr + (AW+1)'(1);
                vld[rd_ptr[AW-1:0]]   <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_req;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_rd[i] = mem[i].rd;
        end
    end

    assign ent_valid = vld;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - ALU/LSU writeback arbiter onto the single register-file write port
module wb_arbiter
    import qar_pkg::*;
#(
    parameter int LSU_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [NUM_REGS-1:0]   pending_mask
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    wb_req_t                             head;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic                                fifo_push;
    logic                                fifo_pop;
    logic [LSU_DEPTH-1:0]                ent_valid;
    logic [LSU_DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;

    logic [SW-1:0]         starve_cnt, cnt_d, cnt_inc;
    logic                  force_lsu, force_d;
    logic                  we_d;
    logic [REG_ADDR_W-1:0] waddr_d;
    logic [XLEN-1:0]       wdata_d;

    wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_req  ('{rd: lsu_rd, data: lsu_data}),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .ent_valid (ent_valid),
        .ent_rd    (ent_rd)
    );

    assign lsu_ready = !rst && !fifo_full;
    // x0 writes are architecturally dropped, so they never occupy a slot.
    assign fifo_push = lsu_valid && lsu_ready && (lsu_rd != '0);

    always_comb begin
        alu_ready = 1'b0;
        fifo_pop  = 1'b0;
        we_d      = 1'b0;
        waddr_d   = rf_waddr;
        wdata_d   = rf_wdata;
        cnt_d     = starve_cnt;
        cnt_inc   = starve_cnt + SW'(1);
        force_d   = force_lsu;
        if (!rst) begin
            alu_ready = 1'b1;
            if (force_lsu && !fifo_empty) begin
                alu_ready = 1'b0;
                fifo_pop  = 1'b1;
                we_d      = 1'b1;
                waddr_d   = head.rd;
                wdata_d   = head.data;
                cnt_d     = '0;
                force_d   = 1'b0;
            end else if (alu_valid) begin
                we_d    = (alu_rd != '0);
                waddr_d = alu_rd;
                wdata_d = alu_data;
                if (fifo_empty) begin
                    cnt_d = '0;
                end else if (cnt_inc == SW'(STARVE_MAX)) begin
                    cnt_d   = '0;
                    force_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else if (!fifo_empty) begin
                fifo_pop = 1'b1;
                we_d     = 1'b1;
                waddr_d  = head.rd;
                wdata_d  = head.data;
                cnt_d    = '0;
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            starve_cnt <= '0;
            force_lsu  <= 1'b0;
        end else begin
            rf_we      <= we_d;
            rf_waddr   <= waddr_d;
            rf_wdata   <= wdata_d;
            starve_cnt <= cnt_d;
            force_lsu  <= force_d;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < LSU_DEPTH; i++) begin
            if (ent_valid[i]) begin
                pending_mask = pending_mask | reg_onehot(ent_rd[i]);
            end
        end
        if (rf_we) begin
            pending_mask = pending_mask | reg_onehot(rf_waddr);
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized scoreboard bench for wb_arbiter
module tb_wb_arbiter;
    import qar_pkg::*;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending_mask;

    always #5 clk = ~clk;

    wb_arbiter #(.LSU_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pending_mask (pending_mask)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t    sb[$];
    wb_req_t mq[$];
    bit      mforce;
    int      mcnt;
    bit      mlast_we;
    logic [4:0] mlast_addr;
    bit      minit;
    int      cyc = 0;
    int      checks = 0;
    int      passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock of stimulus; the model decides readiness and the resulting write.
    task automatic step(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        bit          fc, lacc, we;
        logic [4:0]  wa;
        logic [31:0] wd, m;
        wb_req_t     e;
        @(negedge clk);
        rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        #1;
        wa = '0; wd = '0; we = 1'b0;
        if (r) begin
            check("alu_ready_rst", alu_ready, 0);
            check("lsu_ready_rst", lsu_ready, 0);
            mq.delete();
            mforce = 0; mcnt = 0; mlast_we = 0; minit = 1;
        end else begin
            fc = mforce && mq.size() > 0;
            check("alu_ready", alu_ready, !fc);
            check("lsu_ready", lsu_ready, mq.size() < DEPTH);
            if (minit) begin
                m = '0;
                foreach (mq[i]) m[mq[i].rd] = 1'b1;
                if (mlast_we) m[mlast_addr] = 1'b1;
                m[0] = 1'b0;
                check("pending_mask", pending_mask, m);
            end
            lacc = lv && mq.size() < DEPTH;
            if (fc) begin
                e = mq.pop_front();
                we = 1; wa = e.rd; wd = e.data;
                mforce = 0; mcnt = 0;
            end else if (av) begin
                we = (ard != 0); wa = ard; wd = ad;
                if (mq.size() > 0) begin
                    mcnt++;
                    if (mcnt == SMAX) begin mforce = 1; mcnt = 0; end
                end else mcnt = 0;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                we = 1; wa = e.rd; wd = e.data; mcnt = 0;
            end else mcnt = 0;
            if (lacc && lrd != 0) mq.push_back('{rd: lrd, data: ld});
            mlast_we = we; mlast_addr = wa;
            if (we) sb.push_back('{addr: wa, data: wd, cyc: cyc + 1});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check("rf_we", rf_we, 1);
                check("rf_waddr", rf_waddr, e.addr);
                check("rf_wdata", rf_wdata, e.data);
            end else begin
                check("rf_we_idle", rf_we, 0);
            end
        end
    end

    initial begin : stim
        int pa, pl;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        step(0, 1, 0, 32'h12345678, 0, 0, 0);
        idle(2);
        step(0, 1, 1, 32'hA0, 1, 3, 32'h300);
        step(0, 1, 2, 32'hA1, 1, 7, 32'h700);
        for (int i = 0; i < 12; i++) step(0, 1, 5'(8 + i), 32'hB0 + i, 1, 12, 32'hC00);
        idle(4);
        step(0, 1, 1, 32'h1, 1, 10, 32'hA00);
        step(0, 1, 2, 32'h2, 1, 11, 32'hB00);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 5'(13 + i), 32'hD00 + i);
        idle(4);
        step(0, 1, 4, 32'h44, 1, 9, 32'h99);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(4);
        step(0, 0, 0, 0, 1, 1, 32'h11);
        step(0, 0, 0, 0, 1, 2, 32'h22);
        step(0, 0, 0, 0, 1, 3, 32'h33);
        idle(5);
        for (int blk = 0; blk < 6; blk++) begin
            pa = $urandom_range(10, 95);
            pl = $urandom_range(10, 95);
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(0, 299) == 0,
                     $urandom_range(0, 99) < pa, 5'($urandom), $urandom,
                     $urandom_range(0, 99) < pl, 5'($urandom), $urandom);
            end
        end
        idle(10);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
